// File: rtl/router_out_fifo.sv
// rtl/router_out_fifo.sv - per-port output FIFO of the 1x3 router with header tagging and packet tracking
// Optional feature: define ROUTER_FIFO_LEVEL_EN to add the registered occupancy port "level".
module router_out_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
`ifdef ROUTER_FIFO_LEVEL_EN
  output logic [PTR_W:0]        level,
`endif
  output logic                  in_pkt
);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]      wr_ptr_nxt, rd_ptr_nxt;
  logic [6:0]          pkt_cnt;
  logic                do_wr, do_rd, flush;
  logic [DATA_WIDTH:0] rd_word;

  assign flush   = reset | soft_reset;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign in_pkt  = (pkt_cnt != 7'd0);

  // Flags come from registered pointers, so a full FIFO never bypasses a write into a slot being read.
  assign do_wr   = write_enb && !full;
  assign do_rd   = read_enb && !empty;
  assign rd_word = mem[rd_ptr[PTR_W-1:0]];

  assign wr_ptr_nxt = do_wr ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_ptr_nxt = do_rd ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (!flush && do_wr)
      mem[wr_ptr[PTR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= 7'd0;
      data_out <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (do_rd) begin
        data_out <= rd_word[DATA_WIDTH-1:0];
        // Header byte carries payload length in bits [7:2]; +1 accounts for the trailing parity byte.
        if (rd_word[DATA_WIDTH])
          pkt_cnt <= {1'b0, rd_word[7:2]} + 7'd1;
        else if (pkt_cnt != 7'd0)
          pkt_cnt <= pkt_cnt - 7'd1;
      end
    end
  end

`ifdef ROUTER_FIFO_LEVEL_EN
  always_ff @(posedge clk) begin
    if (flush)
      level <= '0;
    else
      level <= wr_ptr_nxt - rd_ptr_nxt;
  end
`endif

endmodule

// File: tb/tb_router_out_fifo.sv
// tb/tb_router_out_fifo.sv - directed self-checking bench for router_out_fifo
// Checks the level port too when ROUTER_FIFO_LEVEL_EN is defined.
module tb_router_out_fifo;

  logic       clk = 1'b0;
  logic       reset, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, in_pkt;
`ifdef ROUTER_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_out_fifo #(.DATA_WIDTH(8), .DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out),
    .full(full), .empty(empty),
`ifdef ROUTER_FIFO_LEVEL_EN
    .level(level),
`endif
    .in_pkt(in_pkt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef ROUTER_FIFO_LEVEL_EN
    check(tag, {27'd0, level}, exp);
`endif
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1; lfd_state = hdr; data_in = d;
    tick();
    write_enb = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic rd();
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
  endtask

  initial begin
    logic [7:0] pkt [5];
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    read_enb = 1'b0; data_in = 8'h00;

    // 1. reset
    tick(); tick();
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_pkt", in_pkt, 0);
    check("rst_data_out", data_out, 8'h00);
    check_level("rst_level", 0);

    // 2. header 0x0D (len 3), payload, parity 0x0D
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h0D;
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
    check("pkt_empty", empty, 0);
    check_level("pkt_level", 5);
    for (int i = 0; i < 5; i++) begin
      rd();
      check($sformatf("pkt_data%0d", i), data_out, pkt[i]);
      check($sformatf("pkt_in_pkt%0d", i), in_pkt, (i < 4) ? 1 : 0);
    end
    check("pkt_drained", empty, 1);

    // 3. fill, overflow drop, drain, underflow hold
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_notfull%0d", i), full, 0);
      wr(8'h40 + 8'(i), 1'b0);
    end
    check("fill_full", full, 1);
    check_level("fill_level", 16);
    wr(8'hFF, 1'b0);
    check("ovf_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      rd();
      check($sformatf("drain%0d", i), data_out, 8'h40 + 8'(i));
    end
    check("drain_empty", empty, 1);
    rd();
    check("underflow_hold", data_out, 8'h4F);
    check("underflow_empty", empty, 1);
    check("underflow_in_pkt", in_pkt, 0);

    // 4. simultaneous read+write when full, mid and empty
    for (int i = 0; i < 16; i++) wr(8'h50 + 8'(i), 1'b0);
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hAA;
    tick();
    read_enb = 1'b0; write_enb = 1'b0;
    check("rw_full_data", data_out, 8'h50);
    check("rw_full_full", full, 0);
    check_level("rw_full_level", 15);
    for (int i = 0; i < 7; i++) rd();
    check("rw_mid_pre", data_out, 8'h57);
    check_level("rw_mid_pre_level", 8);
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hBB;
    tick();
    read_enb = 1'b0; write_enb = 1'b0;
    check("rw_mid_data", data_out, 8'h58);
    check_level("rw_mid_level", 8);
    for (int i = 0; i < 7; i++) begin
      rd();
      check($sformatf("rw_mid_drain%0d", i), data_out, 8'h59 + 8'(i));
    end
    rd();
    check("rw_mid_last", data_out, 8'hBB);
    check("rw_mid_empty", empty, 1);
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hCC;
    tick();
    read_enb = 1'b0; write_enb = 1'b0;
    check("rw_empty_hold", data_out, 8'hBB);
    check("rw_empty_notempty", empty, 0);
    rd();
    check("rw_empty_data", data_out, 8'hCC);
    check("rw_empty_empty", empty, 1);

    // 5. soft reset mid-packet, then normal traffic
    wr(8'h0D, 1'b1);
    for (int i = 1; i <= 4; i++) wr(8'(i), 1'b0);
    rd();
    check("sr_hdr", data_out, 8'h0D);
    rd();
    check("sr_b1", data_out, 8'h01);
    check("sr_in_pkt_pre", in_pkt, 1);
    soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h77; read_enb = 1'b1;
    tick();
    soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    check("sr_empty", empty, 1);
    check("sr_full", full, 0);
    check("sr_in_pkt", in_pkt, 0);
    check("sr_data_out", data_out, 8'h00);
    check_level("sr_level", 0);
    wr(8'h04, 1'b1); wr(8'h99, 1'b0); wr(8'h9D, 1'b0);
    rd();
    check("post_hdr", data_out, 8'h04);
    check("post_in_pkt0", in_pkt, 1);
    rd();
    check("post_pay", data_out, 8'h99);
    check("post_in_pkt1", in_pkt, 1);
    rd();
    check("post_par", data_out, 8'h9D);
    check("post_in_pkt2", in_pkt, 0);
    // length-0 header: only a parity byte follows
    wr(8'h00, 1'b1); wr(8'h5A, 1'b0);
    rd();
    check("len0_hdr_in_pkt", in_pkt, 1);
    rd();
    check("len0_par", data_out, 8'h5A);
    check("len0_in_pkt", in_pkt, 0);

    // 6. three passes of 12 across the pointer wrap
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 12; i++) begin
        wr(8'(8'h80 + 8'(p * 16 + i)), 1'b0);
        check($sformatf("wrap_wfull_p%0d_%0d", p, i), full, 0);
      end
      check_level($sformatf("wrap_level_p%0d", p), 12);
      for (int i = 0; i < 12; i++) begin
        rd();
        check($sformatf("wrap_data_p%0d_%0d", p, i), data_out, 8'(8'h80 + 8'(p * 16 + i)));
        check($sformatf("wrap_rfull_p%0d_%0d", p, i), full, 0);
      end
      check($sformatf("wrap_empty_p%0d", p), empty, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
